// File: rtl/updown_counter_gen.sv
// Up/down counter with run-time limits, programmable step and wrap/saturate mode.
// Registered overflow/underflow pulses plus sticky flags; high/low flag count at a limit.
module updown_counter_gen #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       STEP_W  = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              up,
  input  logic              down,
  input  logic [WIDTH-1:0]  in,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              high,
  output logic              low,
  output logic              ovf,
  output logic              unf,
  output logic              ovf_stk,
  output logic              unf_stk,
  output logic              cfg_err
);

  localparam int unsigned PadW = WIDTH + 1 - STEP_W;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_stk_q, ovf_stk_d, unf_stk_q, unf_stk_d;
  logic [WIDTH:0]   step_ext, sum, diff;
  logic             up_hit, down_hit, step_nz;

  assign cfg_err  = lo_lim > hi_lim;
  assign step_ext = {{PadW{1'b0}}, step};
  assign sum      = {1'b0, count_q} + step_ext;
  assign diff     = {1'b0, count_q} - step_ext;
  assign step_nz  = |step;
  assign up_hit   = en & up & ~down;
  assign down_hit = en & down & ~up;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (cfg_err) begin
      count_d = count_q;
    end else if (load) begin
      if (in < lo_lim)      count_d = lo_lim;
      else if (in > hi_lim) count_d = hi_lim;
      else                  count_d = in;
    end else if (up_hit && step_nz) begin
      if (sum > {1'b0, hi_lim}) begin
        ovf_d   = 1'b1;
        count_d = sat_mode ? hi_lim : lo_lim;
      end else begin
        count_d = sum[WIDTH-1:0];
      end
    end else if (down_hit && step_nz) begin
      // diff[WIDTH] set means the subtraction borrowed below zero
      if (diff[WIDTH] || (diff[WIDTH-1:0] < lo_lim)) begin
        unf_d   = 1'b1;
        count_d = sat_mode ? lo_lim : hi_lim;
      end else begin
        count_d = diff[WIDTH-1:0];
      end
    end
  end

  // A new event takes precedence over a same-cycle clear
  assign ovf_stk_d = ovf_d | (ovf_stk_q & ~clr_flags);
  assign unf_stk_d = unf_d | (unf_stk_q & ~clr_flags);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= RST_VAL;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ovf_stk_q <= 1'b0;
      unf_stk_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ovf_stk_q <= ovf_stk_d;
      unf_stk_q <= unf_stk_d;
    end
  end

  assign count   = count_q;
  assign high    = count_q == hi_lim;
  assign low     = count_q == lo_lim;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign ovf_stk = ovf_stk_q;
  assign unf_stk = unf_stk_q;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Directed self-checking bench for updown_counter_gen (WIDTH=8, STEP_W=4).
module tb_updown_counter_gen;

  logic       clk, rst, en, load, up, down, sat_mode, clr_flags;
  logic [7:0] in, lo_lim, hi_lim, count;
  logic [3:0] step;
  logic       high, low, ovf, unf, ovf_stk, unf_stk, cfg_err;

  int checks = 0;
  int errors = 0;

  updown_counter_gen #(.WIDTH(8), .STEP_W(4), .RST_VAL(8'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .down(down), .in(in),
    .step(step), .lo_lim(lo_lim), .hi_lim(hi_lim), .sat_mode(sat_mode),
    .clr_flags(clr_flags), .count(count), .high(high), .low(low), .ovf(ovf),
    .unf(unf), .ovf_stk(ovf_stk), .unf_stk(unf_stk), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; load = 1'b0; up = 1'b0; down = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    idle();
    load = 1'b1; in = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; idle(); in = 8'd0; step = 4'd0; sat_mode = 1'b0;
    lo_lim = 8'd0; hi_lim = 8'd255;
    #12;
    check("rst_count", count, 0);
    check("rst_ovf_stk", ovf_stk, 0);
    check("rst_unf_stk", unf_stk, 0);
    rst = 1'b1;
    tick();

    // 1. reset mid-count with a sticky flag set beforehand
    hi_lim = 8'd7; sat_mode = 1'b1;
    do_load(8'd7);
    check("t1_load7", count, 7);
    en = 1'b1; up = 1'b1; step = 4'd1;
    tick();
    idle();
    check("t1_sat_ovf", ovf, 1);
    check("t1_sat_hold", count, 7);
    check("t1_ovf_stk_set", ovf_stk, 1);
    #2 rst = 1'b0;
    #1;
    check("t1_async_count", count, 0);
    check("t1_async_ovf", ovf, 0);
    check("t1_async_ovf_stk", ovf_stk, 0);
    en = 1'b1; up = 1'b1; step = 4'd3; hi_lim = 8'd255;
    tick();
    check("t1_hold_in_rst", count, 0);
    idle();
    #2 rst = 1'b1;
    tick();

    // 2. wrap mode, up by 3 in [2,9]
    lo_lim = 8'd2; hi_lim = 8'd9; sat_mode = 1'b0; step = 4'd3;
    do_load(8'd2);
    check("t2_start", count, 2);
    check("t2_low", low, 1);
    en = 1'b1; up = 1'b1;
    tick(); check("t2_c5", count, 5); check("t2_high5", high, 0);
    tick(); check("t2_c8", count, 8); check("t2_high8", high, 0);
    tick(); check("t2_wrap", count, 2); check("t2_ovf", ovf, 1);
    check("t2_stk", ovf_stk, 1);
    up = 1'b0;
    tick(); check("t2_ovf_pulse_end", ovf, 0); check("t2_stk_keep", ovf_stk, 1);
    clr_flags = 1'b1;
    tick(); check("t2_stk_clr", ovf_stk, 0);
    clr_flags = 1'b0;

    // 3. saturate mode, down by 3 in [2,9]
    sat_mode = 1'b1;
    do_load(8'd8);
    en = 1'b1; down = 1'b1;
    tick(); check("t3_c5", count, 5);
    tick(); check("t3_c2", count, 2); check("t3_low", low, 1); check("t3_no_unf", unf, 0);
    tick(); check("t3_sat", count, 2); check("t3_unf", unf, 1);
    tick(); check("t3_sat2", count, 2); check("t3_unf_again", unf, 1);
    check("t3_unf_stk", unf_stk, 1);
    idle();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("t3_unf_stk_clr", unf_stk, 0);

    // 4. load clamping and priority
    lo_lim = 8'd10; hi_lim = 8'd20;
    do_load(8'd25); check("t4_clamp_hi", count, 20); check("t4_high", high, 1);
    do_load(8'd3);  check("t4_clamp_lo", count, 10); check("t4_lowf", low, 1);
    en = 1'b1; up = 1'b1; load = 1'b1; in = 8'd15;
    tick(); check("t4_load_over_up", count, 15); check("t4_no_ovf", ovf, 0);
    en = 1'b0; up = 1'b0; in = 8'd12;
    tick(); check("t4_load_en0", count, 12);
    load = 1'b0;

    // 5. carry and borrow past the register width
    lo_lim = 8'd0; hi_lim = 8'd255; sat_mode = 1'b0; step = 4'd5;
    do_load(8'd254);
    en = 1'b1; up = 1'b1;
    tick(); check("t5_carry", count, 0); check("t5_ovf", ovf, 1);
    do_load(8'd1);
    en = 1'b1; down = 1'b1;
    tick(); check("t5_borrow", count, 255); check("t5_unf", unf, 1);

    // 6. misc holds, step 0, cfg_err, event with clear
    en = 1'b1; up = 1'b1; down = 1'b1;
    tick(); check("t6_updown_hold", count, 255); check("t6_updown_noovf", ovf, 0);
    en = 1'b0; down = 1'b0;
    tick(); check("t6_en0_hold", count, 255);
    en = 1'b1; step = 4'd0;
    tick(); check("t6_step0_hold", count, 255); check("t6_step0_noovf", ovf, 0);
    idle(); step = 4'd5;
    lo_lim = 8'd9; hi_lim = 8'd2;
    #1 check("t6_cfg_err", cfg_err, 1);
    load = 1'b1; in = 8'd5;
    tick(); check("t6_cfg_frozen", count, 255);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick(); check("t6_cfg_frozen_up", count, 255); check("t6_cfg_noovf", ovf, 0);
    idle();
    lo_lim = 8'd0; hi_lim = 8'd255;
    #1 check("t6_cfg_ok", cfg_err, 0);
    clr_flags = 1'b1;
    tick(); check("t6_clr_ovf", ovf_stk, 0); check("t6_clr_unf", unf_stk, 0);
    en = 1'b1; up = 1'b1;
    tick();
    check("t6_evt_count", count, 0); check("t6_evt_ovf", ovf, 1);
    check("t6_set_wins", ovf_stk, 1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
